// File: rtl/data_mem_responder.sv
// Data-memory responder: services one load/store at a time from a word array
// after a fixed wait and returns aligned, extended load data or an error.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int unsigned AW  = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  LAT = 4'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic        accept, commit;

   logic        lat_write;
   logic [2:0]  lat_funct3;
   logic [31:0] lat_addr, lat_wdata;

   logic        cur_write;
   logic [2:0]  cur_funct3;
   logic [31:0] cur_addr, cur_wdata;

   logic        illegal_f3, out_of_range, misaligned, err;
   logic [AW-1:0] idx;
   logic [31:0] word, shifted, load_data, lane_data;
   logic [15:0] half;
   logic [3:0]  be;

   logic        rsp_valid_q, rsp_error_q;
   logic [31:0] rsp_rdata_q;

   logic [31:0] mem [DEPTH_WORDS];

   assign req_ready = (state == S_IDLE) && !reset;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      commit     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (req_ready && req_valid) begin
               accept = 1'b1;
               if (LAT == 4'd0) begin
                  state_next = S_RESP;
                  commit     = 1'b1;
               end else begin
                  state_next = S_WAIT;
                  cnt_next   = LAT;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd1) begin
               state_next = S_RESP;
               commit     = 1'b1;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // With zero latency the commit edge is the acceptance edge, so the live
   // request is used in IDLE and the latched copy everywhere else.
   always_comb begin
      cur_write  = (state == S_IDLE) ? req_write  : lat_write;
      cur_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;
      cur_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
      cur_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;
   end

   always_comb begin
      illegal_f3 = 1'b1;
      if (cur_write) begin
         unique case (cur_funct3)
            3'b000, 3'b001, 3'b010: illegal_f3 = 1'b0;
            default:                illegal_f3 = 1'b1;
         endcase
      end else begin
         unique case (cur_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_f3 = 1'b0;
            default:                                illegal_f3 = 1'b1;
         endcase
      end
      out_of_range = |cur_addr[31:AW+2];
      misaligned   = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                     ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
      err          = illegal_f3 || out_of_range || misaligned;
      idx          = cur_addr[AW+1:2];
   end

   always_comb begin
      word    = mem[idx];
      shifted = word >> {cur_addr[1:0], 3'b000};
      half    = cur_addr[1] ? word[31:16] : word[15:0];
      unique case (cur_funct3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_data = {24'h0, shifted[7:0]};
         3'b001:  load_data = {{16{half[15]}}, half};
         3'b101:  load_data = {16'h0, half};
         default: load_data = word;
      endcase
   end

   always_comb begin
      unique case (cur_funct3[1:0])
         2'b00: begin
            be        = 4'b0001 << cur_addr[1:0];
            lane_data = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            be        = cur_addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{cur_wdata[15:0]}};
         end
         default: begin
            be        = 4'b1111;
            lane_data = cur_wdata;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         rsp_valid_q <= commit;
         rsp_error_q <= commit && err;
         rsp_rdata_q <= (commit && !err && !cur_write) ? load_data : '0;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         lat_write  <= req_write;
         lat_funct3 <= req_funct3;
         lat_addr   <= req_addr;
         lat_wdata  <= req_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && commit && cur_write && !err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's load/store port: it accepts one load or store request at a time, services it from an internal word array after a fixed, parameterised wait, and returns one response. It sits on the far side of the datapath's data-memory interface. The datapath drives the address (ALU result), store data (register read port 2) and the access size (funct3). The responder returns load data, already aligned and sign- or zero-extended, ready for the register write-back mux.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two, ≥ 4.
- LATENCY, 2: wait cycles between the acceptance edge and the response cycle; range 0..15.

Ports:
- clock  input  1  single clock; everything samples on its rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  access size and sign, using RISC-V funct3 encoding.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  load result; 0 for stores and for errors.
- rsp_error  output  1  request was rejected; qualified by rsp_valid.

## Operation
- Array size and indexing:
  - AW = log2(DEPTH_WORDS).
  - Word index is req_addr[AW+1:2].
  - Address is out of range if req_addr[31:AW+2] ≠ 0.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- An error is flagged for any of:
  - an illegal funct3;
  - an out-of-range address;
  - misalignment: a halfword with addr[0] = 1, or a word with addr[1:0] ≠ 00.
- An erroring request:
  - never modifies the array;
  - returns rsp_rdata = 0 and rsp_error = 1.
- Store lane selection:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - All other lanes are untouched.
- Load extraction:
  - The selected byte or halfword is shifted to bit 0.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
- Array contents are not cleared by reset.
- FSM states:
  - IDLE: req_ready = 1. If req_valid = 1, the request is accepted and latched. The next state is WAIT when LATENCY > 0, otherwise RESP.
  - WAIT: req_ready = 0. A down-counter is loaded with LATENCY at acceptance. When the count reaches 1, the next state is RESP.
  - RESP: rsp_valid = 1 and req_ready = 0 for exactly one cycle. The next state is always IDLE.
- Commit point: the store write and the load read both happen at the edge that enters RESP, using the latched request.
  - req_* inputs after acceptance are ignored.
  - A load that immediately follows a store to the same word returns the new data.

## Timing
- Reset values, in the cycle after reset is sampled high:
  - state = IDLE;
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0;
  - req_ready = 0 while reset is high, then 1 from the first cycle after reset deasserts.
- Latency: a request accepted in cycle t produces rsp_valid in cycle t+LATENCY+1.
- req_ready returns to 1 in cycle t+LATENCY+2.
- Maximum throughput is one request per LATENCY+2 cycles.
- Handshake: transfer occurs iff req_valid & req_ready at a rising edge. There is no cancellation after acceptance.
- Reset mid-operation (in WAIT, or at the edge entering RESP): the pending request is dropped.
  - No array write occurs.
  - rsp_valid stays 0.
  - A store already committed on an earlier edge remains.
- The WAIT counter must not underflow: LATENCY = 0 bypasses WAIT entirely, and LATENCY = 1 spends exactly one cycle in WAIT.
- Outputs are registered; rsp_rdata and rsp_error are 0 whenever rsp_valid = 0.

## Test plan
- Reset then idle, LATENCY = 2 -> req_ready = 1 from the first post-reset cycle; rsp_valid = 0, rsp_rdata = 0.
- SW 0xDEADBEEF to 0x10, then LW 0x10 -> the LW response has rsp_rdata = 0xDEADBEEF, rsp_error = 0, and rsp_valid asserts exactly 3 cycles after acceptance.
- With word 0x10 = 0xDEADBEEF:
  - LB 0x13 -> 0xFFFFFFDE;
  - LBU 0x13 -> 0x000000DE;
  - LH 0x12 -> 0xFFFFDEAD;
  - LHU 0x10 -> 0x0000BEEF.
- SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF. SH 0x1234 to 0x12, then LW 0x10 -> 0x123455EF.
- Error cases -> rsp_error = 1 and rsp_rdata = 0 for each:
  - LW 0x11;
  - LH 0x13;
  - funct3 = 011;
  - an address of 4·DEPTH_WORDS.
  A following LW 0x10 still returns 0x123455EF.
- Reset and latency corners:
  - Assert reset 1 cycle after accepting SW 0xCAFEF00D to 0x20 -> no rsp_valid, and LW 0x20 afterwards does not return 0xCAFEF00D.
  - Repeat the latency checks at LATENCY = 0 -> rsp_valid in cycle t+1, req_ready back in cycle t+2.
